edit_mem_freeb_mc: RTL and testbench

Multi-requestor free buffer manager for the edit memory. Builds a free list of `NUM_BUF` buffer pointers after reset or on request, hands pointers to up to `NUM_REQ` requestors through a round-robin req/gnt handshake, and returns released pointers to the list. Sits between the edit-memory write clients (PUs, DMA) and the edit memory buffer RAM; replaces the single-client free buffer controller.

---
 rtl/edit_mem_freeb_mc.sv | 263 ++++++++++++++++++++++++++
 tb/tb_edit_mem_freeb_mc.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/edit_mem_freeb_mc.sv
// edit_mem_freeb_mc: multi-requestor free buffer manager for the edit memory.
// Builds a free list of NUM_BUF pointers (after reset or freeb_init), issues
// pointers to NUM_REQ requestors by round-robin req/gnt, and relists released
// pointers. Storage is a RAM FIFO followed by a two-stage prefetch (read stage
// + head register), so one grant per cycle can be sustained.
// Optional feature: define EM_FREEB_DBL_FREE_CHK_EN to add an allocation bitmap
// that rejects double frees and out-of-range releases.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | one cycle after reset or a rebuild request
// ST_CLEAR | list pointers, head, count (and bitmap) are zeroed
// ST_FILL  | writes 0..NUM_BUF-1 into the FIFO, one per cycle
// ST_READY | in service: grants and releases accepted, init_done=1
module edit_mem_freeb_mc #(
    parameter int BPTR_NBITS = 10,
    parameter int NUM_BUF    = 1024,
    parameter int NUM_REQ    = 4,
    parameter int LOW_WM     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeb_init,
    input  logic                  rel_valid,
    input  logic [BPTR_NBITS-1:0] rel_ptr,
    input  logic [NUM_REQ-1:0]    req,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [BPTR_NBITS-1:0] buf_ptr,
    output logic                  init_done,
    output logic [BPTR_NBITS:0]   free_count,
    output logic                  low_wm,
    output logic                  rel_err
);

    localparam int DEPTH = 1 << BPTR_NBITS;
    localparam int CW    = BPTR_NBITS + 1;
    localparam int RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [CW-1:0]         NUM_BUF_C  = CW'(NUM_BUF);
    localparam logic [CW-1:0]         LOW_WM_C   = CW'(LOW_WM);
    localparam logic [BPTR_NBITS-1:0] LAST_PTR_C = BPTR_NBITS'(NUM_BUF - 1);
    localparam logic [RR_W-1:0]       LAST_REQ_C = RR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FILL,
        ST_READY
    } state_t;

    state_t state, state_nxt;

    logic [BPTR_NBITS-1:0] fill_ptr;
    logic                  ready;
    logic                  clearing;
    logic                  filling;

    // RAM FIFO
    logic [BPTR_NBITS-1:0] mem [DEPTH];
    logic [BPTR_NBITS-1:0] wr_ptr;
    logic [BPTR_NBITS-1:0] rd_ptr;
    logic [CW-1:0]         fifo_cnt;
    logic                  wr_en;
    logic [BPTR_NBITS-1:0] wr_data;
    logic                  rd_en;

    // Prefetch: read stage then head register
    logic                  rd_vld;
    logic [BPTR_NBITS-1:0] rd_data;
    logic                  head_vld;
    logic [BPTR_NBITS-1:0] head_ptr;
    logic                  move;
    logic                  rd_free;
    logic                  byp;

    // Registered release
    logic                  rel_q_vld;
    logic [BPTR_NBITS-1:0] rel_q_ptr;
    logic                  rel_chk_ok;
    logic                  rel_ok;
    logic                  rel_bad;

    // Arbitration
    logic [RR_W-1:0]       rr_ptr;
    logic [RR_W-1:0]       gnt_idx;
    logic                  take;
    logic                  found;
    int unsigned           scan_idx;

    logic [CW-1:0]         cnt_nxt;

    assign ready     = (state == ST_READY);
    assign clearing  = (state == ST_CLEAR);
    assign filling   = (state == ST_FILL);
    assign init_done = ready;
    assign buf_ptr   = head_ptr;
    assign take      = |gnt;

    // Init FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Init FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  state_nxt = ST_CLEAR;
            ST_CLEAR: state_nxt = ST_FILL;
            ST_FILL:  if (fill_ptr == LAST_PTR_C) state_nxt = ST_READY;
            ST_READY: if (freeb_init) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Fill pointer walks 0..NUM_BUF-1 during FILL
    always_ff @(posedge clk) begin
        if (rst || clearing) fill_ptr <= '0;
        else if (filling)    fill_ptr <= fill_ptr + 1'b1;
    end

    // Round-robin search starting at rr_ptr; a grant needs a valid head
    always_comb begin
        gnt      = '0;
        gnt_idx  = '0;
        found    = 1'b0;
        scan_idx = 0;
        if (ready && head_vld) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                scan_idx = 32'(rr_ptr) + 32'(k);
                if (scan_idx >= 32'(NUM_REQ)) scan_idx = scan_idx - 32'(NUM_REQ);
                if (!found && req[scan_idx]) begin
                    found         = 1'b1;
                    gnt[scan_idx] = 1'b1;
                    gnt_idx       = RR_W'(scan_idx);
                end
            end
        end
    end

    // Priority moves to the client after the one just granted
    always_ff @(posedge clk) begin
        if (rst) rr_ptr <= '0;
        else if (take) rr_ptr <= (gnt_idx == LAST_REQ_C) ? '0 : gnt_idx + 1'b1;
    end

`ifdef EM_FREEB_DBL_FREE_CHK_EN
    localparam int MAP_W = $clog2(NUM_BUF);

    logic [NUM_BUF-1:0] alloc_map;
    logic [MAP_W-1:0]   rel_idx;
    logic [MAP_W-1:0]   gnt_map_idx;
    logic               rel_in_range;

    assign rel_idx      = rel_ptr[MAP_W-1:0];
    assign gnt_map_idx  = head_ptr[MAP_W-1:0];
    assign rel_in_range = (32'(rel_ptr) < 32'(NUM_BUF));
    assign rel_chk_ok   = (free_count != NUM_BUF_C) && rel_in_range && alloc_map[rel_idx];

    // Allocation bitmap: set on grant, cleared on an accepted release
    always_ff @(posedge clk) begin
        if (rst || clearing) begin
            alloc_map <= '0;
        end else begin
            if (rel_ok) alloc_map[rel_idx]     <= 1'b0;
            if (take)   alloc_map[gnt_map_idx] <= 1'b1;
        end
    end
`else
    // Without the bitmap only a full list can reject a release
    assign rel_chk_ok = (free_count != NUM_BUF_C);
`endif

    assign rel_ok  = rel_valid && ready && !freeb_init && rel_chk_ok;
    assign rel_bad = rel_valid && ready && !freeb_init && !rel_chk_ok;

    // Release register; rel_err reports a dropped release one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            rel_q_vld <= 1'b0;
            rel_q_ptr <= '0;
            rel_err   <= 1'b0;
        end else begin
            rel_q_vld <= rel_ok;
            rel_q_ptr <= rel_ptr;
            rel_err   <= rel_bad;
        end
    end

    // Prefetch control: bypass a release straight into the read stage when
    // the FIFO is empty so it keeps its place and reaches the head quickly
    always_comb begin
        move    = ready && rd_vld && (!head_vld || take);
        rd_free = !rd_vld || move;
        rd_en   = ready && rd_free && (fifo_cnt != '0);
        byp     = ready && rd_free && (fifo_cnt == '0) && rel_q_vld;
        wr_en   = filling || (ready && rel_q_vld && !byp);
        wr_data = filling ? fill_ptr : rel_q_ptr;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst || clearing) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            fifo_cnt <= fifo_cnt + CW'(wr_en) - CW'(rd_en);
        end
    end

    // FIFO storage write port
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    // Read stage data: RAM output or bypassed release
    always_ff @(posedge clk) begin
        if (rd_en)    rd_data <= mem[rd_ptr];
        else if (byp) rd_data <= rel_q_ptr;
    end

    // Head register data follows the read stage
    always_ff @(posedge clk) begin
        if (move) head_ptr <= rd_data;
    end

    // Prefetch valid flags
    always_ff @(posedge clk) begin
        if (rst || clearing) begin
            rd_vld   <= 1'b0;
            head_vld <= 1'b0;
        end else begin
            if (rd_en || byp) rd_vld <= 1'b1;
            else if (move)    rd_vld <= 1'b0;
            if (move)         head_vld <= 1'b1;
            else if (take)    head_vld <= 1'b0;
        end
    end

    // Next free count: FIFO entries plus head, tracked as events happen
    always_comb begin
        cnt_nxt = free_count;
        if (clearing)     cnt_nxt = '0;
        else if (filling) cnt_nxt = free_count + 1'b1;
        else if (ready)   cnt_nxt = free_count + CW'(rel_ok) - CW'(take);
    end

    // Registered count and low-watermark flag
    always_ff @(posedge clk) begin
        if (rst) begin
            free_count <= '0;
            low_wm     <= 1'b1;
        end else begin
            free_count <= cnt_nxt;
            low_wm     <= (cnt_nxt < LOW_WM_C);
        end
    end

endmodule

// File: tb/tb_edit_mem_freeb_mc.sv
// Bench for edit_mem_freeb_mc: random and directed stimulus, with a queue-based
// model of the free list checked by a negedge monitor.
module tb_edit_mem_freeb_mc;

    localparam int BPTR = 4;
    localparam int NB   = 16;
    localparam int NR   = 4;
    localparam int LWM  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            freeb_init;
    logic            rel_valid;
    logic [BPTR-1:0] rel_ptr;
    logic [NR-1:0]   req;
    logic [NR-1:0]   gnt;
    logic [BPTR-1:0] buf_ptr;
    logic            init_done;
    logic [BPTR:0]   free_count;
    logic            low_wm;
    logic            rel_err;

    always #5 clk = ~clk;

    edit_mem_freeb_mc #(
        .BPTR_NBITS(BPTR),
        .NUM_BUF   (NB),
        .NUM_REQ   (NR),
        .LOW_WM    (LWM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .freeb_init(freeb_init),
        .rel_valid (rel_valid),
        .rel_ptr   (rel_ptr),
        .req       (req),
        .gnt       (gnt),
        .buf_ptr   (buf_ptr),
        .init_done (init_done),
        .free_count(free_count),
        .low_wm    (low_wm),
        .rel_err   (rel_err)
    );

    typedef struct {
        int ptr;
        int ready_at;
    } ent_t;

    int   n_chk = 0;
    int   n_fail = 0;
    ent_t free_q[$];
    int   held[$];
    int   cyc = 0;
    int   k = 0;
    int   rr = 0;
    bit   exp_err = 1'b0;
    bit   built = 1'b0;
    bit   rst_prev = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int find_held(input int p);
        for (int i = 0; i < held.size(); i++)
            if (held[i] == p) return i;
        return -1;
    endfunction

    function automatic int rr_pick(input int start, input logic [NR-1:0] r);
        for (int i = 0; i < NR; i++)
            if (r[(start + i) % NR]) return (start + i) % NR;
        return -1;
    endfunction

    // Monitor: compare outputs with the model, then apply this cycle's events
    always @(negedge clk) begin
        int  sz0;
        bit  rdy;
        bit  exp_any;
        int  idx;
        int  hi;
        bit  ok;
        int  ra;
        cyc++;
        if (rst) begin
            if (rst_prev) begin
                chk("rst_gnt", int'(gnt), 0);
                chk("rst_init_done", int'(init_done), 0);
                chk("rst_free_count", int'(free_count), 0);
                chk("rst_low_wm", int'(low_wm), 1);
                chk("rst_rel_err", int'(rel_err), 0);
            end
            k = 0;
            free_q.delete();
            held.delete();
            rr = 0;
            exp_err = 1'b0;
            built = 1'b0;
        end else begin
            rdy = (k >= NB + 2);
            if (rdy && !built) begin
                for (int p = 0; p < NB; p++) free_q.push_back('{p, cyc + 2});
                built = 1'b1;
            end
            sz0 = free_q.size();
            chk("init_done", int'(init_done), int'(rdy));
            chk("rel_err", int'(rel_err), int'(exp_err));
            if (rdy) begin
                chk("free_count", int'(free_count), sz0);
                chk("low_wm", int'(low_wm), int'(sz0 < LWM));
            end
            exp_any = rdy && (req != '0) && (sz0 > 0) && (free_q[0].ready_at <= cyc);
            chk("gnt_any", int'(|gnt), int'(exp_any));
            if (exp_any && (gnt != '0)) begin
                idx = rr_pick(rr, req);
                chk("gnt_onehot", int'(gnt), 1 << idx);
                chk("buf_ptr", int'(buf_ptr), free_q[0].ptr);
                held.push_back(free_q[0].ptr);
                void'(free_q.pop_front());
                rr = (idx + 1) % NR;
            end
            exp_err = 1'b0;
            if (rel_valid && rdy && !freeb_init) begin
                ok = (sz0 < NB);
                hi = find_held(int'(rel_ptr));
`ifdef EM_FREEB_DBL_FREE_CHK_EN
                ok = ok && (hi >= 0);
`endif
                if (ok) begin
                    ra = cyc + 3;
                    if (free_q.size() > 0 && free_q[free_q.size()-1].ready_at > ra)
                        ra = free_q[free_q.size()-1].ready_at;
                    free_q.push_back('{int'(rel_ptr), ra});
                    if (hi >= 0) held.delete(hi);
                end else begin
                    exp_err = 1'b1;
                end
            end
            if (rdy && freeb_init) begin
                k = 0;
                free_q.delete();
                held.delete();
                built = 1'b0;
            end else if (k < 100000) begin
                k++;
            end
        end
        rst_prev = rst;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic release_ptr(input int p);
        rel_valid = 1'b1;
        rel_ptr   = BPTR'(p);
    endtask

    // Driver
    initial begin
        rst = 1'b1; freeb_init = 1'b0; rel_valid = 1'b0; rel_ptr = '0; req = '0;
        repeat (3) tick();
        rst = 1'b0;

        // Single requestor drains the whole list
        req = 4'b0001;
        repeat (NB + 24) tick();
        req = '0;
        tick();

        // Release into an empty list with req[2] waiting
        release_ptr(7);
        req = 4'b0100;
        tick();
        rel_valid = 1'b0;
        repeat (5) tick();
        req = '0;
        tick();

        // Build up five free entries, then grant+release in one cycle
        for (int p = 0; p < 5; p++) begin
            release_ptr(p);
            tick();
        end
        rel_valid = 1'b0;
        repeat (4) tick();
        req = 4'b0010;
        release_ptr(5);
        tick();
        req = '0;
        rel_valid = 1'b0;
        repeat (3) tick();

`ifdef EM_FREEB_DBL_FREE_CHK_EN
        // Pointer 0 was granted above; release it twice
        release_ptr(0);
        tick();
        release_ptr(0);
        tick();
        rel_valid = 1'b0;
        repeat (2) tick();
`endif

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            req = NR'($urandom_range(0, (1 << NR) - 1));
            if (held.size() > 0 && $urandom_range(0, 1) == 1)
                release_ptr(held[$urandom_range(0, held.size() - 1)]);
            else
                rel_valid = 1'b0;
            tick();
        end
        req = '0;
        rel_valid = 1'b0;
        tick();

        // Return everything, then release into a full list
        for (int i = 0; i < 4 * NB && held.size() > 0; i++) begin
            release_ptr(held[0]);
            tick();
            rel_valid = 1'b0;
        end
        repeat (3) tick();
        release_ptr(5);
        tick();
        rel_valid = 1'b0;
        repeat (3) tick();

        // Five grants, then rebuild; releases during rebuild are ignored
        req = 4'b1111;
        repeat (5) tick();
        req = '0;
        freeb_init = 1'b1;
        tick();
        freeb_init = 1'b0;
        for (int i = 0; i < 6; i++) begin
            release_ptr(i);
            tick();
        end
        rel_valid = 1'b0;
        req = 4'b1111;
        repeat (NB + 25) tick();

        // Reset mid-operation, then more random traffic
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        for (int i = 0; i < 120; i++) begin
            req = NR'($urandom_range(0, (1 << NR) - 1));
            if (held.size() > 0 && $urandom_range(0, 2) == 0)
                release_ptr(held[$urandom_range(0, held.size() - 1)]);
            else
                rel_valid = 1'b0;
            tick();
        end
        req = '0;
        rel_valid = 1'b0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
